// File: rtl/ms_wb_arb_pkg.sv
// ms_wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter.
// Contents:
//   state_t         - arbiter states (IDLE, BUSY)
//   TO_DATA_DEFAULT - read data handed back on a timed-out transfer
//   TO_CNT_W        - width of the watchdog counter
package ms_wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [31:0] TO_DATA_DEFAULT = 32'hDEADBEEF;
    localparam int          TO_CNT_W        = 16;

endpackage

// File: rtl/ms_wb_watchdog.sv
// ms_wb_watchdog
// Saturating bus watchdog counter used by the arbiter.
// Ports:
//   clk  in  - clock, rising edge
//   rst  in  - asynchronous active-high reset
//   clr  in  - synchronous clear (takes priority over en)
//   en   in  - count enable
//   hit  out - high while the count equals TIMEOUT-1
module ms_wb_watchdog
    import ms_wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [TO_CNT_W-1:0] HIT_VAL = TO_CNT_W'(TIMEOUT - 1);

    logic [TO_CNT_W-1:0] cnt;

    // Saturate at all-ones so a stuck enable can never wrap back to a
    // value that would look like a fresh transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {TO_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/ms_wb_arb2.sv
// ms_wb_arb2
// Two-master to one-slave Wishbone arbiter with round-robin grant per
// transfer and a watchdog that terminates stalled transfers.
// Ports:
//   clk_i, rst_i            - clock and asynchronous active-high reset
//   m0_* / m1_*             - Wishbone master-side ports (cyc/stb/we/sel/adr/dat in,
//                             dat/ack out)
//   s_*                     - Wishbone slave-side port
//   gnt_o                   - one-hot grant, 00 when idle
//   to_o                    - one-cycle pulse on a watchdog timeout
module ms_wb_arb2
    import ms_wb_arb_pkg::*;
#(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = TO_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        to_o
);

    state_t      state;
    logic [1:0]  gnt;
    logic        rr_ptr;

    logic        req0;
    logic        req1;
    logic        busy;
    logic        fwd_cyc;
    logic        fwd_stb;
    logic        ack_ok;
    logic        hit;
    logic        timeout;
    logic        done;
    logic [1:0]  next_gnt;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign busy = (state == BUSY);

    // Forward the granted master's request to the slave. gnt is only
    // non-zero in BUSY, so the slave side reads all zeros while idle.
    always_comb begin
        fwd_cyc = 1'b0;
        fwd_stb = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        if (gnt[0]) begin
            fwd_cyc = m0_cyc_i;
            fwd_stb = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt[1]) begin
            fwd_cyc = m1_cyc_i;
            fwd_stb = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // A real slave ack beats a watchdog hit in the same cycle.
    assign ack_ok  = busy & s_ack_i & fwd_cyc & fwd_stb;
    assign timeout = busy & hit & ~ack_ok;
    assign done    = ack_ok | ~fwd_cyc | timeout;

    assign s_cyc_o  = fwd_cyc & ~timeout;
    assign s_stb_o  = fwd_stb & ~timeout;
    assign m0_ack_o = gnt[0] & (ack_ok | timeout);
    assign m1_ack_o = gnt[1] & (ack_ok | timeout);
    assign m0_dat_o = timeout ? TO_DATA : s_dat_i;
    assign m1_dat_o = timeout ? TO_DATA : s_dat_i;
    assign gnt_o    = gnt;
    assign to_o     = timeout;

    // Grant choice from IDLE: a lone requester wins, a tie goes to rr_ptr.
    always_comb begin
        next_gnt = 2'b00;
        if (req0 && req1) begin
            next_gnt = rr_ptr ? 2'b10 : 2'b01;
        end else if (req0) begin
            next_gnt = 2'b01;
        end else if (req1) begin
            next_gnt = 2'b10;
        end
    end

    // Every transfer end (ack, abort or timeout) returns to IDLE for one
    // cycle and hands priority to the master that was not just served.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            gnt    <= 2'b00;
            rr_ptr <= 1'b0;
        end else if (!busy) begin
            if (next_gnt != 2'b00) begin
                state <= BUSY;
                gnt   <= next_gnt;
            end
        end else if (done) begin
            state  <= IDLE;
            gnt    <= 2'b00;
            rr_ptr <= gnt[0];
        end
    end

    ms_wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk(clk_i),
        .rst(rst_i),
        .clr(~busy & (req0 | req1)),
        .en (busy & ~ack_ok),
        .hit(hit)
    );

endmodule

// File: tb/tb_ms_wb_arb2.sv
// tb_ms_wb_arb2
// Directed bench for ms_wb_arb2 (TIMEOUT=8). Expected acknowledge responses
// are queued when stimulus is issued and consumed by an independent monitor
// whenever either master sees an ack; static signal checks are made inline.
module tb_ms_wb_arb2;

    typedef struct {
        int          m;
        logic [31:0] d;
        logic        to;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;
    logic        to_o;

    logic        auto_ack;
    logic        man_ack;
    logic [31:0] man_dat;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    logic [1:0]  sat_gnt [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [31:0] sat_dat [5] = '{32'hFFFFFEFF, 32'h0, 32'hFFFFFDFF, 32'h0, 32'hFFFFFEFF};

    ms_wb_arb2 #(
        .TIMEOUT(8),
        .TO_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .to_o(to_o)
    );

    always #5 clk_i = ~clk_i;

    // Slave model: either acks every granted cycle with ~address as data,
    // or follows the manually driven ack/data.
    assign s_ack_i = auto_ack ? (gnt_o != 2'b00) : man_ack;
    assign s_dat_i = auto_ack ? ~s_adr_o : man_dat;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic req, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = req; m0_stb_i = req; m0_we_i = we;
            m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = req; m1_stb_i = req; m1_we_i = we;
            m1_sel_i = 4'hF; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expectAck(input int m, input logic [31:0] d, input logic to);
        exp_q.push_back('{m, d, to});
    endtask

    // Monitor: every master ack (or stray to_o) consumes one queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i && (m0_ack_o || m1_ack_o || to_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_ack: got m0_ack=%b m1_ack=%b to=%b expected none",
                         m0_ack_o, m1_ack_o, to_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ((m0_ack_o && m1_ack_o) || (m1_ack_o ? 1 : 0) != mon_e.m || !(m0_ack_o || m1_ack_o) ||
                    (m1_ack_o ? m1_dat_o : m0_dat_o) !== mon_e.d || to_o !== mon_e.to) begin
                    errors++;
                    $display("[TB] FAIL ack_resp: got m0_ack=%b m1_ack=%b dat=%h to=%b expected master=%0d dat=%h to=%b",
                             m0_ack_o, m1_ack_o, (m1_ack_o ? m1_dat_o : m0_dat_o), to_o,
                             mon_e.m, mon_e.d, mon_e.to);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        auto_ack = 1'b0; man_ack = 1'b0; man_dat = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_i = 1'b1;
        #12 rst_i = 1'b0;

        // Reset state, then a spurious ack while idle must be ignored.
        @(negedge clk_i);
        checkOutput("rst_gnt", gnt_o, 2'b00);
        checkOutput("rst_s_cyc", s_cyc_o, 0);
        checkOutput("rst_s_stb", s_stb_o, 0);
        checkOutput("rst_to", to_o, 0);
        man_ack = 1'b1;
        @(negedge clk_i);
        checkOutput("spur_m0_ack", m0_ack_o, 0);
        checkOutput("spur_m1_ack", m1_ack_o, 0);
        tick();
        man_ack = 1'b0;

        // Single m0 read, slave acks on the fourth BUSY cycle.
        applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        tick();
        @(negedge clk_i);
        checkOutput("s1_gnt", gnt_o, 2'b01);
        checkOutput("s1_s_stb", s_stb_o, 1);
        checkOutput("s1_s_adr", s_adr_o, 32'h1000);
        tick();
        tick();
        tick();
        man_ack = 1'b1; man_dat = 32'h12345678;
        expectAck(0, 32'h12345678, 1'b0);
        @(negedge clk_i);
        checkOutput("s1_m1_ack", m1_ack_o, 0);
        tick();
        man_ack = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("s1_idle", gnt_o, 2'b00);

        // Fresh reset, then both masters saturate: grants alternate.
        tick();
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h200, 32'h0);
        auto_ack = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (sat_gnt[i] != 2'b00) expectAck(sat_gnt[i] == 2'b10 ? 1 : 0, sat_dat[i], 1'b0);
            @(negedge clk_i);
            checkOutput($sformatf("sat_gnt%0d", i), gnt_o, sat_gnt[i]);
            tick();
        end
        auto_ack = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("sat_idle", gnt_o, 2'b00);

        // m1 with a silent slave: timeout on the eighth BUSY cycle.
        applyStimulus(1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) expectAck(1, 32'hDEADBEEF, 1'b1);
            @(negedge clk_i);
            checkOutput($sformatf("to_s_cyc_c%0d", c), s_cyc_o, (c < 8) ? 32'd1 : 32'd0);
            if (c == 8) checkOutput("to_s_stb", s_stb_o, 0);
            else        checkOutput($sformatf("to_pulse_c%0d", c), to_o, 0);
            tick();
        end
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0);
        @(negedge clk_i);
        checkOutput("to_idle", gnt_o, 2'b00);
        checkOutput("to_idle_pulse", to_o, 0);

        // m0 acked exactly on the would-be timeout cycle: normal completion.
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                man_ack = 1'b1; man_dat = 32'hCAFEF00D;
                expectAck(0, 32'hCAFEF00D, 1'b0);
                @(negedge clk_i);
                checkOutput("tie_s_cyc", s_cyc_o, 1);
            end
            tick();
        end
        man_ack = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Abort: m1 granted (priority after m0), drops cyc, then m0 served.
        applyStimulus(0, 1'b1, 1'b0, 32'h500, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h600, 32'h0);
        @(negedge clk_i);
        checkOutput("ab_dead", gnt_o, 2'b00);
        tick();
        @(negedge clk_i);
        checkOutput("ab_gnt1", gnt_o, 2'b10);
        checkOutput("ab_s_adr", s_adr_o, 32'h600);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("ab_s_cyc", s_cyc_o, 0);
        tick();
        @(negedge clk_i);
        checkOutput("ab_idle", gnt_o, 2'b00);
        tick();
        man_ack = 1'b1; man_dat = 32'h0BADCAFE;
        expectAck(0, 32'h0BADCAFE, 1'b0);
        @(negedge clk_i);
        checkOutput("ab_gnt0", gnt_o, 2'b01);
        checkOutput("ab_s_adr0", s_adr_o, 32'h500);
        tick();
        man_ack = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of a BUSY cycle takes effect without a clock edge.
        applyStimulus(0, 1'b1, 1'b0, 32'h700, 32'h0);
        tick();
        @(negedge clk_i);
        checkOutput("rb_gnt", gnt_o, 2'b01);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1; man_ack = 1'b1;
        #1;
        checkOutput("rb_gnt_rst", gnt_o, 2'b00);
        checkOutput("rb_s_cyc", s_cyc_o, 0);
        checkOutput("rb_s_stb", s_stb_o, 0);
        checkOutput("rb_m0_ack", m0_ack_o, 0);
        checkOutput("rb_to", to_o, 0);
        #2;
        rst_i = 1'b0; man_ack = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 32'h800, 32'h000055AA);
        tick();
        man_ack = 1'b1; man_dat = 32'h00000001;
        expectAck(1, 32'h00000001, 1'b0);
        @(negedge clk_i);
        checkOutput("rb_gnt1", gnt_o, 2'b10);
        checkOutput("rb_s_we", s_we_o, 1);
        checkOutput("rb_s_dat", s_dat_o, 32'h000055AA);
        tick();
        man_ack = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("rb_idle", gnt_o, 2'b00);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ms_wb_arb2.md
# ms_wb_arb2

Two-master to one-slave Wishbone arbiter that shares a single user-area peripheral (typically the PSRAM controller) between the management SoC Wishbone port and a second master such as a DMA engine. It sits between the masters and the peripheral's Wishbone slave port. Arbitration is round-robin per transfer. A bus watchdog terminates stalled transfers with a known data pattern and reports a timeout.

## Interface
- `TIMEOUT`, 255: cycles in BUSY without slave ack before forced termination; legal range 2..65535.
- `TO_DATA`, 32'hDEADBEEF: read data returned on a timed-out transfer.

Ports:
- `clk_i` input 1: single clock, all logic on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` input 1 each: master 0 bus-cycle, strobe and write-enable.
- `m0_sel_i` input 4: master 0 byte selects.
- `m0_adr_i`, `m0_dat_i` input 32 each: master 0 address and write data.
- `m0_dat_o` output 32: master 0 read data.
- `m0_ack_o` output 1: master 0 acknowledge.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1 each: slave bus-cycle, strobe and write-enable.
- `s_sel_o` output 4: slave byte selects.
- `s_adr_o`, `s_dat_o` output 32 each: slave address and write data.
- `s_dat_i` input 32: slave read data.
- `s_ack_i` input 1: slave acknowledge.
- `gnt_o` output 2: one-hot current grant; 00 when idle.
- `to_o` output 1: one-cycle pulse when a timeout occurs.

## Operation
- States are IDLE and BUSY. Registers: `state`, `gnt` (one-hot), `rr_ptr` (1 bit, the master with priority on a tie), and `to_cnt` (16-bit).
- **IDLE.** A master requests when `cyc&stb` is high.
  - Only one master requests: that master is granted.
  - Both request: master `rr_ptr` is granted.
  - On a grant: `gnt` is loaded, `to_cnt` is cleared, and the state goes to BUSY.
  - In IDLE, all `s_*` outputs are 0 and both `m*_ack_o` are 0.
- **BUSY.** The granted master's `cyc/stb/we/sel/adr/dat` are forwarded combinationally to `s_*`.
  - `s_ack_i` is forwarded combinationally to the granted master only. The other master's ack is held at 0.
  - Both `m*_dat_o` carry `s_dat_i`, except on a timeout cycle (see below).
- **BUSY to IDLE on any of the following:**
  - Slave ack (`s_ack_i` with `s_stb_o` high): normal completion. `rr_ptr` is set to the non-granted master.
  - Granted master drops `cyc`: abort. The slave sees `cyc` low in the same cycle, because it is forwarded. `rr_ptr` is updated as for completion.
  - Timeout: `to_cnt` equals `TIMEOUT-1` and there is no ack in that cycle. In that cycle:
    - the granted master gets `ack=1` and `dat_o=TO_DATA`;
    - `s_cyc_o` and `s_stb_o` are forced to 0;
    - `to_o` is 1.
    - `rr_ptr` is updated as for completion.
- **Counter.** `to_cnt` increments every BUSY cycle without ack and saturates; it never wraps.
- **Ack and timeout in the same cycle.** Ack wins: it is a normal completion, with no `to_o` and the slave data returned.
- **Spurious ack.** A slave ack while in IDLE is ignored.
- **Reset.** Asynchronous reset, including mid-transfer, forces:
  - `state`=IDLE, `gnt`=00, `rr_ptr`=0, `to_cnt`=0;
  - `s_cyc_o`/`s_stb_o`=0, `m*_ack_o`=0, `to_o`=0.
  - Masters must restart any transfer that was in flight.

## Timing
- Grant latency: request seen at edge N in IDLE, so BUSY and slave `stb` are visible from cycle N+1.
- One mandatory IDLE cycle after every completion, abort or timeout. Back-to-back transfers from one master are therefore spaced by at least one dead cycle.
- Ack path `s_ack_i` to `m*_ack_o` is combinational, with zero added latency.
- A master holding `cyc&stb` continuously is served at least every second transfer. With both masters saturating, grants strictly alternate.
- A timeout fires exactly `TIMEOUT` cycles after BUSY entry, counting the first BUSY cycle as 1.

## Structure
- Shared package `ms_wb_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - the `TO_DATA` default;
  - the `to_cnt` width constant (16).
- One sub-module, `ms_wb_watchdog`: the saturating counter with clear/enable inputs and a `hit` output at `TIMEOUT-1`.
- Grant selection and muxing stay in the top.

## Test plan
- Single master 0 read with slave ack 3 cycles after `stb`:
  - `gnt_o`=01 one cycle after the request;
  - `m0_ack_o` coincides with `s_ack_i`;
  - `m0_dat_o`=slave data (e.g. 32'h12345678);
  - `to_o` stays 0.
- Both masters request simultaneously after reset: m0 served first, then m1 after one IDLE cycle. Continuing saturation gives the grant sequence 01,00,10,00,01.
- Slave never acks, `TIMEOUT`=8: exactly 8 BUSY cycles, then `m*_ack_o`=1, `dat_o`=32'hDEADBEEF, `to_o` pulses once, and `s_cyc_o` is low in that cycle.
- Slave acks in the same cycle the timeout would hit: normal data returned and `to_o`=0.
- Granted master drops `cyc` mid-transfer: `s_cyc_o` falls the same cycle, IDLE next cycle, and the other pending master is granted after that.
- `rst_i` asserted mid-BUSY: all outputs go to their reset values immediately, without waiting for a clock edge. After release, a new m1 request is granted normally.
